// File: rtl/crc24_attach_if.sv
// rtl/crc24_attach_if.sv - payload-in / code-block-out handshake bundle for crc24_attach
interface crc24_attach_if;
    logic       vld_in;
    logic       cbs_in;
    logic [7:0] data_in;
    logic       rdy_in;
    logic       rdy_crc;
    logic       vld_crc;
    logic       cbs;
    logic [7:0] data_out;
    logic       last_byte;

    modport master (
        output vld_in, cbs_in, data_in, rdy_crc,
        input  rdy_in, vld_crc, cbs, data_out, last_byte
    );

    modport slave (
        input  vld_in, cbs_in, data_in, rdy_crc,
        output rdy_in, vld_crc, cbs, data_out, last_byte
    );
endinterface

// File: rtl/crc24_attach.sv
// rtl/crc24_attach.sv - buffers a code-block payload, appends LTE CRC-24B and streams the K-bit block
module crc24_attach #(
    parameter int          K_SMALL  = 1056,
    parameter int          K_LARGE  = 6144,
    parameter logic [23:0] CRC_POLY = 24'h800063
) (
    input  logic           clk,
    input  logic           reset,
    crc24_attach_if.slave  bus
);

    localparam int DEPTH = K_LARGE / 8;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] N_S   = CW'(K_SMALL / 8);
    localparam logic [CW-1:0] N_L   = CW'(K_LARGE / 8);
    localparam logic [CW-1:0] NM1_S = CW'(K_SMALL / 8 - 1);
    localparam logic [CW-1:0] NM1_L = CW'(K_LARGE / 8 - 1);
    localparam logic [CW-1:0] PM1_S = CW'(K_SMALL / 8 - 4);
    localparam logic [CW-1:0] PM1_L = CW'(K_LARGE / 8 - 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_APPEND,
        S_WAIT,
        S_HDR,
        S_STREAM
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [1:0]    app_cnt;
    logic [23:0]   crc;
    logic          cbs_lat;

    logic [7:0]    mem [0:DEPTH-1];
    logic          we;
    logic [7:0]    wd;
    logic          acc;

    // Serial MSB-first LFSR unrolled over one byte, data_in[0] entering first.
    function automatic logic [23:0] crc_step(input logic [23:0] c_in, input logic [7:0] d);
        logic [23:0] c;
        c = c_in;
        for (int b = 0; b < 8; b++) begin
            if (c[23] ^ d[b])
                c = {c[22:0], 1'b0} ^ CRC_POLY;
            else
                c = {c[22:0], 1'b0};
        end
        return c;
    endfunction

    // CRC byte j carries remainder bit p(8j+b) = crc[23-(8j+b)] at bit b.
    function automatic logic [7:0] crc_byte(input logic [23:0] c, input logic [1:0] j);
        logic [7:0] s;
        logic [7:0] r;
        case (j)
            2'd0:    s = c[23:16];
            2'd1:    s = c[15:8];
            default: s = c[7:0];
        endcase
        for (int b = 0; b < 8; b++)
            r[b] = s[7-b];
        return r;
    endfunction

    assign acc = bus.vld_in && bus.rdy_in && (state == S_IDLE || state == S_LOAD);

    always_comb begin
        we = 1'b0;
        wd = 8'h00;
        if (acc) begin
            we = 1'b1;
            wd = bus.data_in;
        end else if (state == S_APPEND) begin
            we = 1'b1;
            wd = crc_byte(crc, app_cnt);
        end
    end

    // Payload and CRC bytes both land at buffer[count].
    always_ff @(posedge clk) begin
        if (we)
            mem[count] <= wd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            count         <= '0;
            app_cnt       <= '0;
            crc           <= '0;
            cbs_lat       <= 1'b0;
            bus.rdy_in    <= 1'b0;
            bus.vld_crc   <= 1'b0;
            bus.cbs       <= 1'b0;
            bus.data_out  <= 8'h00;
            bus.last_byte <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.rdy_in <= 1'b1;
                    if (acc) begin
                        cbs_lat <= bus.cbs_in;
                        crc     <= crc_step(crc, bus.data_in);
                        count   <= CW'(1);
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (acc) begin
                        crc   <= crc_step(crc, bus.data_in);
                        count <= count + CW'(1);
                        if (count == (cbs_lat ? PM1_L : PM1_S)) begin
                            bus.rdy_in <= 1'b0;
                            app_cnt    <= '0;
                            state      <= S_APPEND;
                        end
                    end
                end
                S_APPEND: begin
                    count   <= count + CW'(1);
                    app_cnt <= app_cnt + 2'd1;
                    if (app_cnt == 2'd2)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.rdy_crc) begin
                        bus.vld_crc <= 1'b1;
                        bus.cbs     <= cbs_lat;
                        state       <= S_HDR;
                    end
                end
                S_HDR: begin
                    // Fetch byte 0 during the header so it is on data_out the cycle after.
                    bus.vld_crc   <= 1'b0;
                    bus.cbs       <= 1'b0;
                    bus.data_out  <= mem[0];
                    bus.last_byte <= (NM1_S == '0);
                    count         <= CW'(1);
                    state         <= S_STREAM;
                end
                S_STREAM: begin
                    if (count == (cbs_lat ? N_L : N_S)) begin
                        bus.last_byte <= 1'b0;
                        bus.rdy_in    <= 1'b1;
                        crc           <= '0;
                        count         <= '0;
                        state         <= S_IDLE;
                    end else begin
                        bus.data_out  <= mem[count];
                        bus.last_byte <= (count == (cbs_lat ? NM1_L : NM1_S));
                        count         <= count + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc24_attach.sv
// tb/tb_crc24_attach.sv - scoreboard bench for crc24_attach
module tb_crc24_attach;

    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    crc24_attach_if bus();

    crc24_attach #(
        .K_SMALL  (1056),
        .K_LARGE  (6144),
        .CRC_POLY (24'h800063)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  exp_q[$];
    logic        exp_cbs_q[$];
    int          exp_len_q[$];
    int          hdr_cnt = 0;
    int          blocks_done = 0;
    int          mon_idx = 0;
    int          cur_len = 0;
    bit          streaming = 0;
    logic [23:0] res_crc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] ref_step(input logic [23:0] c_in, input logic [7:0] d);
        logic [23:0] c;
        logic        fb;
        c = c_in;
        for (int b = 0; b < 8; b++) begin
            fb = c[23] ^ d[b];
            c  = {c[22:0], 1'b0};
            if (fb) c = c ^ 24'h800063;
        end
        return c;
    endfunction

    task automatic push_exp(input logic cbs, input byte_q_t bytes);
        foreach (bytes[i]) exp_q.push_back(bytes[i]);
        exp_len_q.push_back(bytes.size());
        exp_cbs_q.push_back(cbs);
    endtask

    task automatic send_block(input logic cbs, input byte_q_t pl, input bit gaps);
        for (int i = 0; i < pl.size(); i++) begin
            int guard;
            bit ok;
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.vld_in = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            bus.vld_in  = 1'b1;
            bus.data_in = pl[i];
            bus.cbs_in  = (i == 0) ? cbs : ~cbs;
            guard = 0;
            do begin
                ok = bus.rdy_in;
                @(posedge clk);
                #1;
                guard++;
            end while (!ok && guard < 200);
            if (!ok) begin
                check("rdy_in_timeout", ok, 1);
                break;
            end
        end
        bus.vld_in = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int g;
        g = 0;
        while (blocks_done < target && g < 3000) begin
            @(posedge clk);
            g++;
        end
        #1;
        check($sformatf("block_%0d_done", target), blocks_done >= target, 1);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            streaming = 0;
            exp_q.delete();
            exp_cbs_q.delete();
            exp_len_q.delete();
        end else if (bus.vld_crc) begin
            check("hdr_during_stream", streaming, 0);
            check("hdr_expected", exp_cbs_q.size() > 0, 1);
            if (exp_cbs_q.size() > 0) begin
                check("hdr_cbs", bus.cbs, exp_cbs_q.pop_front());
                cur_len = exp_len_q.pop_front();
            end
            check("hdr_last_byte", bus.last_byte, 0);
            hdr_cnt++;
            streaming = 1;
            mon_idx   = 0;
            res_crc   = '0;
        end else if (streaming) begin
            logic [7:0] e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check($sformatf("data_%0d", mon_idx), bus.data_out, e);
            check($sformatf("last_%0d", mon_idx), bus.last_byte, mon_idx == cur_len - 1);
            res_crc = ref_step(res_crc, bus.data_out);
            mon_idx++;
            if (mon_idx == cur_len) begin
                check("crc_residual", res_crc, 0);
                streaming = 0;
                blocks_done++;
            end
        end else begin
            check("idle_last_byte", bus.last_byte, 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t     pl;
        byte_q_t     ex;
        logic [23:0] c;
        int          g;

        reset       = 1'b1;
        bus.vld_in  = 1'b0;
        bus.cbs_in  = 1'b0;
        bus.data_in = 8'h00;
        bus.rdy_crc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy_in", bus.rdy_in, 0);
        check("rst_vld_crc", bus.vld_crc, 0);
        check("rst_cbs", bus.cbs, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_last_byte", bus.last_byte, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_rdy_in", bus.rdy_in, 1);

        // 1: all-zero small block, rdy_crc held high
        bus.rdy_crc = 1'b1;
        pl = {};
        for (int i = 0; i < 129; i++) pl.push_back(8'h00);
        ex = pl;
        ex.push_back(8'h00); ex.push_back(8'h00); ex.push_back(8'h00);
        push_exp(1'b0, ex);
        send_block(1'b0, pl, 1'b0);
        wait_done(1);
        repeat (10) @(posedge clk);
        #1;
        check("one_hdr_blk1", hdr_cnt, 1);

        // 2: single 1 in the final bit of a small block
        pl = {};
        for (int i = 0; i < 128; i++) pl.push_back(8'h00);
        pl.push_back(8'h80);
        ex = pl;
        ex.push_back(8'h01); ex.push_back(8'h00); ex.push_back(8'hC6);
        push_exp(1'b0, ex);
        send_block(1'b0, pl, 1'b0);
        wait_done(2);

        // 3: same pattern on a large block
        pl = {};
        for (int i = 0; i < 764; i++) pl.push_back(8'h00);
        pl.push_back(8'h80);
        ex = pl;
        ex.push_back(8'h01); ex.push_back(8'h00); ex.push_back(8'hC6);
        push_exp(1'b1, ex);
        send_block(1'b1, pl, 1'b0);
        wait_done(3);

        // 4: random payload, input gaps, interleaver back-pressure
        bus.rdy_crc = 1'b0;
        pl = {};
        c  = '0;
        for (int i = 0; i < 129; i++) begin
            pl.push_back(8'($urandom_range(0, 255)));
            c = ref_step(c, pl[i]);
        end
        ex = pl;
        for (int j = 0; j < 3; j++) begin
            logic [7:0] cb;
            for (int b = 0; b < 8; b++) cb[b] = c[23 - (8 * j + b)];
            ex.push_back(cb);
        end
        push_exp(1'b0, ex);
        send_block(1'b0, pl, 1'b1);
        check("rdy_in_after_last", bus.rdy_in, 0);
        for (int i = 0; i < 53; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rdy_in_wait_%0d", i), bus.rdy_in, 0);
        end
        check("no_hdr_while_held", hdr_cnt, 3);
        bus.rdy_crc = 1'b1;
        wait_done(4);

        // 5: reset in mid-stream, then a fresh block
        pl = {};
        for (int i = 0; i < 129; i++) pl.push_back(8'h00);
        ex = pl;
        ex.push_back(8'h00); ex.push_back(8'h00); ex.push_back(8'h00);
        push_exp(1'b0, ex);
        send_block(1'b0, pl, 1'b0);
        g = 0;
        while (!(streaming && mon_idx == 40) && g < 3000) begin
            @(posedge clk);
            g++;
        end
        check("reached_byte40", streaming && mon_idx == 40, 1);
        #3;
        reset = 1'b1;
        #1;
        check("abort_data_out", bus.data_out, 0);
        check("abort_last_byte", bus.last_byte, 0);
        check("abort_vld_crc", bus.vld_crc, 0);
        check("abort_rdy_in", bus.rdy_in, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        push_exp(1'b0, ex);
        send_block(1'b0, pl, 1'b0);
        wait_done(5);
        repeat (5) @(posedge clk);
        #1;
        check("final_hdr_cnt", hdr_cnt, 6);
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
